// File: rtl/vcve2_multdiv_issue_if.sv
// Bundle of decoder request/response and multdiv drive signals for the multdiv issue controller.
// The slave modport is the controller's view; master is the decoder/multdiv side.
interface vcve2_multdiv_issue_if #(
    parameter int CntW = 6
);
    // request port from the decoder
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [1:0]      req_signed;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic            req_dit;
    logic            flush;

    // drive side towards the multiplier/divider
    logic            mult_en;
    logic            div_en;
    logic            mult_sel;
    logic            div_sel;
    logic [1:0]      operator;
    logic [1:0]      signed_mode;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic            data_ind_timing;
    logic            multdiv_ready_id;
    logic            md_valid;
    logic [31:0]     md_result;

    // response port
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_result;
    logic [CntW-1:0] rsp_cycles;
    logic            lat_err;

    modport slave (
        input  req_valid, req_op, req_signed, req_a, req_b, req_dit, flush,
        output req_ready,
        output mult_en, div_en, mult_sel, div_sel, operator, signed_mode,
        output op_a, op_b, data_ind_timing, multdiv_ready_id,
        input  md_valid, md_result,
        output rsp_valid, rsp_result, rsp_cycles, lat_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_signed, req_a, req_b, req_dit, flush,
        input  req_ready,
        input  mult_en, div_en, mult_sel, div_sel, operator, signed_mode,
        input  op_a, op_b, data_ind_timing, multdiv_ready_id,
        output md_valid, md_result,
        input  rsp_valid, rsp_result, rsp_cycles, lat_err,
        output rsp_ready
    );
endinterface

// File: rtl/vcve2_multdiv_issue.sv
// ID-side issue controller for the vcve2 multdiv: issues one op, measures its latency, returns the result.
// Optional latency check against the data-independent-timing figures: define VCVE2_MULTDIV_LAT_CHECK_EN.
module vcve2_multdiv_issue #(
    parameter int CntW       = 6,
    parameter int MulLatency = 4,
    parameter int DivLatency = 37
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    vcve2_multdiv_issue_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e          state_reg, state_next;
    logic [1:0]      op_reg;
    logic [1:0]      signed_reg;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    logic            dit_reg;
    logic [CntW-1:0] cnt_reg;
    logic [CntW-1:0] cnt_inc;
    logic [31:0]     result_reg;
    logic [CntW-1:0] cycles_reg;

    logic            is_mul;
    logic            accept;
    logic            capture;
    logic            handshake;

    // MULL/MULH have op[1]=0, DIV/REM have op[1]=1
    assign is_mul  = ~op_reg[1];
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CntW'(1);

    assign accept    = (state_reg == IDLE)  && bus.req_valid;
    assign capture   = (state_reg == ISSUE) && bus.md_valid && !bus.flush;
    assign handshake = (state_reg == RESP)  && bus.rsp_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        bus.req_ready        = 1'b0;
        bus.mult_en          = 1'b0;
        bus.div_en           = 1'b0;
        bus.mult_sel         = 1'b0;
        bus.div_sel          = 1'b0;
        bus.multdiv_ready_id = 1'b0;
        bus.rsp_valid        = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.mult_en          = is_mul;
                bus.mult_sel         = is_mul;
                bus.div_en           = ~is_mul;
                bus.div_sel          = ~is_mul;
                bus.multdiv_ready_id = 1'b1;
                // a flush coinciding with md_valid discards the result
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (bus.md_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_reg     <= '0;
            signed_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            dit_reg    <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            cycles_reg <= '0;
        end else begin
            if (accept) begin
                op_reg     <= bus.req_op;
                signed_reg <= bus.req_signed;
                a_reg      <= bus.req_a;
                b_reg      <= bus.req_b;
                dit_reg    <= bus.req_dit;
                cnt_reg    <= '0;
            end else if (state_reg == ISSUE) begin
                cnt_reg <= cnt_inc;
            end
            if (capture) begin
                result_reg <= bus.md_result;
                cycles_reg <= cnt_inc;
            end
        end
    end

    assign bus.operator        = op_reg;
    assign bus.signed_mode     = signed_reg;
    assign bus.op_a            = a_reg;
    assign bus.op_b            = b_reg;
    assign bus.data_ind_timing = dit_reg;
    assign bus.rsp_result      = result_reg;
    assign bus.rsp_cycles      = cycles_reg;

`ifdef VCVE2_MULTDIV_LAT_CHECK_EN
    logic            lat_err_reg;
    logic [CntW-1:0] exp_lat;
    logic            lat_mismatch;

    assign exp_lat      = is_mul ? CntW'(MulLatency) : CntW'(DivLatency);
    assign lat_mismatch = dit_reg && (cnt_inc != exp_lat);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_err_reg <= 1'b0;
        end else if (capture) begin
            lat_err_reg <= lat_mismatch;
        end else if (handshake) begin
            lat_err_reg <= 1'b0;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && capture) begin
            assert (!lat_mismatch);
        end
    end

    assign bus.lat_err = lat_err_reg;
`else
    assign bus.lat_err = 1'b0;
`endif

endmodule
